// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : result_drain
//  Purpose  : Streams a contiguous block of output-SRAM words to a
//             ready/valid sink, one word per read, with back-pressure.
//  Revision : 1.0 - initial release
// ============================================================================
module result_drain #(
  parameter int Addr_Width     = 5,
  parameter int Ram_Depth      = 1 << Addr_Width,
  parameter int Para_Deg       = 1,
  parameter int Data_Width_Out = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [Addr_Width-1:0]              base_addr,
  input  logic [Addr_Width:0]                num_words,
  output logic                               rd_en,
  output logic [Addr_Width-1:0]              rd_addr,
  input  logic [Para_Deg*Data_Width_Out-1:0] rd_data,
  output logic [Para_Deg*Data_Width_Out-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int                    DW        = Para_Deg * Data_Width_Out;
  // Largest word count a single drain may request; larger requests clamp here.
  localparam logic [Addr_Width:0]   DEPTH_CNT = (Addr_Width + 1)'(Ram_Depth);
  // Highest valid SRAM address; the address counter wraps to zero after it.
  localparam logic [Addr_Width-1:0] LAST_ADDR = Addr_Width'(Ram_Depth - 1);
  localparam logic [Addr_Width-1:0] ADDR_ONE  = Addr_Width'(1);
  localparam logic [Addr_Width:0]   CNT_ONE   = (Addr_Width + 1)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [Addr_Width-1:0] addr;
  logic [Addr_Width:0]   remaining;
  logic [Addr_Width:0]   num_clamped;
  logic                  accept;
  logic                  handshake;
  logic                  last_word;

  assign num_clamped = (num_words > DEPTH_CNT) ? DEPTH_CNT : num_words;
  // A new drain is only taken in IDLE, so start while busy has no effect.
  assign accept      = (state == IDLE) && start && (num_words != '0);
  assign handshake   = (state == SEND) && out_ready;
  assign last_word   = (remaining == CNT_ONE);
  assign rd_addr     = addr;

  // State register; reset aborts any drain immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (num_words == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = last_word;
        if (out_ready) begin
          state_nxt = last_word ? FINISH : FETCH;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Address and word counters: loaded on accept, stepped on each non-final handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr      <= base_addr;
      remaining <= num_clamped;
    end else if (handshake && !last_word) begin
      remaining <= remaining - CNT_ONE;
      addr      <= (addr == LAST_ADDR) ? '0 : (addr + ADDR_ONE);
    end
  end

  // Output word register: SRAM data lands one cycle after FETCH and is held through SEND.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
    end else if (state == CAPTURE) begin
      out_data <= rd_data[DW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_drain
//  Purpose  : Directed self-checking bench for result_drain with an SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_drain;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int DW    = 16;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data   = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic          last_q[$];
  int            done_cnt;
  int            rd_cnt;
  int            first_rd;
  int            first_val;
  logic          timed_out;

  result_drain #(
    .Addr_Width    (AW),
    .Ram_Depth     (DEPTH),
    .Para_Deg      (1),
    .Data_Width_Out(DW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int n);
    base_addr = AW'(b);
    num_words = (AW + 1)'(n);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic set_expect(input int b, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
  endtask

  // Runs the sink from the cycle after the start edge until done, then scores.
  task automatic drain(input string tag, input int stall_idx, input int stall_len,
                       input int inject_at, input int budget);
    logic [DW-1:0] held;
    int            stall_left;
    bit            stalling;
    int            n;
    held       = '0;
    stall_left = stall_len;
    stalling   = 1'b0;
    got_q.delete();
    last_q.delete();
    done_cnt   = 0;
    rd_cnt     = 0;
    first_rd   = -1;
    first_val  = -1;
    timed_out  = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (c == inject_at) begin
        start     = 1'b1;
        base_addr = AW'(20);
        num_words = (AW + 1)'(3);
      end else begin
        start = 1'b0;
      end
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
      end
      if (out_valid && first_val < 0) first_val = c;
      if (stalling) check_val({tag, "_valid_held"}, 32'(out_valid), 32'd1);
      stalling = 1'b0;
      if (out_valid) begin
        if (stall_len > 0 && got_q.size() == stall_idx) begin
          if (stall_left < stall_len) check_val({tag, "_stall_hold"}, 32'(out_data), 32'(held));
          else held = out_data;
        end
        if (stall_len > 0 && got_q.size() == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stalling = 1'b1;
          check_val({tag, "_stall_rd_en"}, 32'(rd_en), 32'd0);
        end else begin
          out_ready = 1'b1;
          got_q.push_back(out_data);
          last_q.push_back(out_last);
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
      step();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check_val({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check_val($sformatf("%s_last%0d", tag, i), 32'(last_q[i]),
                (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
    end
    check_val({tag, "_reads"}, 32'(rd_cnt), 32'(exp_q.size()));
    check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    step();
    check_val({tag, "_done_after"}, 32'(done), 32'd0);
    check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);

    // Reset state
    #2;
    check_val("rst_rd_en", 32'(rd_en), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Full-depth drain, mem[i]=i*3, with latency of the first read and word
    set_expect(0, 32);
    do_start(0, 32);
    drain("seq", -1, 0, -1, 200);
    check_val("seq_first_rd", 32'(first_rd), 32'd0);
    check_val("seq_first_valid", 32'(first_val), 32'd2);

    // Oversize request clamps to the SRAM depth
    set_expect(5, 32);
    do_start(5, 40);
    drain("clamp", -1, 0, -1, 200);

    // Address wrap from the top of the SRAM
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    set_expect(30, 4);
    do_start(30, 4);
    drain("wrap", -1, 0, -1, 60);

    // Back-pressure: sink stalls 4 cycles on word 2
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    set_expect(10, 5);
    do_start(10, 5);
    drain("stall", 2, 4, -1, 80);

    // Zero-length request: done only, no reads, no output
    do_start(3, 0);
    check_val("zero_done", 32'(done), 32'd1);
    check_val("zero_rd_en", 32'(rd_en), 32'd0);
    check_val("zero_valid", 32'(out_valid), 32'd0);
    step();
    check_val("zero_done_after", 32'(done), 32'd0);
    check_val("zero_busy_after", 32'(busy), 32'd0);
    check_val("zero_valid_after", 32'(out_valid), 32'd0);

    // Start pulse during an active drain is ignored
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
    set_expect(4, 6);
    do_start(4, 6);
    drain("ignore", -1, 0, 3, 80);

    // Reset during word index 2 of 8 aborts asynchronously
    do_start(0, 8);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check_val("abort_pre_valid", 32'(out_valid), 32'd1);
    check_val("abort_pre_data", 32'(out_data), 32'(mem[2]));
    #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_valid", 32'(out_valid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_last", 32'(out_last), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_rd_addr", 32'(rd_addr), 32'd0);
    check_val("abort_out_data", 32'(out_data), 32'd0);
    step();
    check_val("abort_done_hold", 32'(done), 32'd0);
    step();
    reset_n = 1'b1;
    check_val("abort_done_release", 32'(done), 32'd0);
    set_expect(0, 2);
    do_start(0, 2);
    drain("post_rst", -1, 0, -1, 40);
    check_val("post_rst_first_rd", 32'(first_rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
